// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word lines and a byte-wide refill port.
// Optional hit/miss statistics counters are built in when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re_IF_i,
  input  logic [31:0] addr_IF_i,
  output logic [31:0] data_CACHE_o,
  output logic        miss_CACHE_o,
  output logic        req_MEM_o,
  output logic [31:0] addr_MEM_o,
  input  logic [7:0]  data_MEM_i,
  input  logic        valid_MEM_i,
  output logic [1:0]  state_dbg_o
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_array  [LINES];
  logic [31:0]           data_array [LINES];
  logic [31:0]           fill_addr;
  logic [31:0]           buffer;
  logic [1:0]            byte_cnt;
  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  hit;
  logic                  start_fill;
  logic                  unused_addr_bits;

  assign idx      = addr_IF_i[INDEX_BITS+1:2];
  assign tag      = addr_IF_i[31 -: TAG_BITS];
  assign fill_idx = fill_addr[INDEX_BITS+1:2];
  assign fill_tag = fill_addr[31 -: TAG_BITS];
  assign unused_addr_bits = ^addr_IF_i[1:0];

  // Hits are only served from IDLE so IF never sees a line that is mid-refill.
  assign hit          = re_IF_i && valid_q[idx] && (tag_array[idx] == tag) && (state == IDLE);
  assign data_CACHE_o = hit ? data_array[idx] : 32'd0;
  assign miss_CACHE_o = re_IF_i && !hit;
  assign start_fill   = (state == IDLE) && miss_CACHE_o;
  assign state_dbg_o  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      fill_addr  <= 32'd0;
      byte_cnt   <= 2'd0;
      buffer     <= 32'd0;
      req_MEM_o  <= 1'b0;
      addr_MEM_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) begin
            state      <= FILL;
            fill_addr  <= {addr_IF_i[31:2], 2'b00};
            addr_MEM_o <= {addr_IF_i[31:2], 2'b00};
            byte_cnt   <= 2'd0;
            req_MEM_o  <= 1'b1;
          end
        end
        FILL: begin
          if (valid_MEM_i) begin
            buffer[{byte_cnt, 3'b000} +: 8] <= data_MEM_i;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= WRITE;
              req_MEM_o <= 1'b0;
            end else begin
              addr_MEM_o <= fill_addr + {30'd0, byte_cnt + 2'd1};
            end
          end
        end
        WRITE: begin
          valid_q[fill_idx] <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      data_array[fill_idx] <= buffer;
      tag_array[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      if (hit)        hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (start_fill) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache. Sits directly downstream of the IF stage: it takes IF's fetch address and returns the instruction word or a miss flag.
- On a miss it fills one word from main memory over the byte-wide memory-controller port.
- Hit path is combinational so IF sees data in the same cycle it presents an address.
- One-word lines, one valid bit per line; no write path (instruction memory is read-only).

Parameters:
- INDEX_BITS, 7, number of index bits; 2^INDEX_BITS one-word lines (128 lines = 512 B default).
- TAG_BITS, 23, tag width = 32 - 2 - INDEX_BITS; must be kept consistent with INDEX_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- re_IF_i  input  1  fetch request from IF; lookup is ignored when low.
- addr_IF_i  input  32  fetch byte address from IF; bits [1:0] ignored.
- data_CACHE_o  output  32  instruction word to IF (combinational).
- miss_CACHE_o  output  1  high while the requested word is not yet available (combinational).
- req_MEM_o  output  1  byte read request to memory controller.
- addr_MEM_o  output  32  byte address of current memory read.
- data_MEM_i  input  8  returned byte.
- valid_MEM_i  input  1  data_MEM_i valid this cycle; one pulse per requested byte.

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- hit = re_IF_i && valid[index] && tag_array[index]==tag && state==IDLE.
- data_CACHE_o = hit ? data_array[index] : 0.
- miss_CACHE_o = re_IF_i && !hit. It is 0 whenever re_IF_i is 0, in any state.
- FSM states:
  - IDLE -> FILL when re_IF_i && !hit. Latch fill_addr = {addr_IF_i[31:2],2'b00}; byte_cnt = 0.
  - FILL: req_MEM_o=1, addr_MEM_o = fill_addr + byte_cnt. On valid_MEM_i, store data_MEM_i into buffer byte lane byte_cnt (little-endian: byte 0 -> bits [7:0]) and increment byte_cnt. When valid_MEM_i arrives with byte_cnt==3, go to WRITE.
  - WRITE (1 cycle): write buffer to data_array[fill index], set tag and valid for that line; req_MEM_o=0; go to IDLE.
- Miss-to-hit latency: first hit appears the cycle after WRITE, provided memory returns bytes back-to-back. Minimum miss penalty: 4 byte returns + 1 WRITE cycle + the 1 IDLE-entry cycle.
- Fill uses the latched fill_addr only. If addr_IF_i changes during FILL/WRITE (e.g. a jump), the fill completes unchanged. The new address is then looked up in IDLE and may miss again.
- req_MEM_o is held high for the whole of FILL, including cycles without valid_MEM_i. addr_MEM_o changes only on the cycle after a valid_MEM_i.
- valid_MEM_i outside FILL is ignored.
- Refilling a line that is already valid overwrites its tag and data; no victim handling.
- Reset values (also forced on a mid-fill reset, whose partial buffer is discarded): all valid bits 0, state IDLE, byte_cnt 0, req_MEM_o 0, addr_MEM_o 0, buffer 0. The data and tag arrays need no reset.
- data_CACHE_o and miss_CACHE_o are combinational and follow the reset state: with re_IF_i low during reset both are 0.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments once per cycle in which hit is high.
  - miss_cnt_o increments once per IDLE->FILL transition, not per miss cycle.
  - Both counters are reset to 0 by rst and wrap modulo 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: after reset, re=1, addr=0x0; memory returns 0x13,0x05,0x10,0x00 -> addr_MEM_o steps 0x0,0x1,0x2,0x3; miss=1 throughout; the cycle after WRITE, miss=0 and data=0x00100513.
- Hit: repeat addr=0x0 -> miss=0 same cycle, data=0x00100513, req_MEM_o stays 0.
- Conflict eviction: fill 0x0, then fill 0x200 (same index, default params) -> 0x200 hits. Re-access 0x0 -> miss, new fill at addr_MEM_o=0x0.
- Slow memory: valid_MEM_i pulses every 3rd cycle -> req_MEM_o held high, each addr_MEM_o value held until its byte returns, line correct after 4 bytes.
- Address change mid-fill: miss on 0x4, switch addr to 0x40 after 2 bytes -> fill of 0x4 completes. Then 0x40 misses and fills. A later access to 0x4 hits.
- Reset mid-fill: assert rst low after byte 2 -> req_MEM_o=0 and state IDLE immediately. After release, 0x4 misses again.
- With ICACHE_STATS_EN defined: the eviction sequence above gives miss_cnt_o=3 and hit_cnt_o equal to the number of hit cycles.
